// File: rtl/iram_arb_pkg.sv
// -----------------------------------------------------------------------------
// iram_arb_pkg
// Shared definitions for the instruction-RAM arbiter:
//   - owner_e        : which requester owns the read response in flight
//   - STARVE_MAX_DEF : default number of consecutive fetch losses tolerated
//                      before the fetch port is forced to win arbitration
// -----------------------------------------------------------------------------
package iram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_PEND = 2'd1,
    ST_DM_PEND = 2'd2
  } owner_e;

  localparam int STARVE_MAX_DEF = 4;

endpackage : iram_arb_pkg

// File: rtl/iram_arb.sv
// -----------------------------------------------------------------------------
// iram_arb
// Arbitrates a single-read / single-write instruction RAM between an
// instruction-fetch port and a data-memory port.
//   - dm writes always win the write port, granted in the same cycle, and are
//     acknowledged one cycle later with dm_rvalid_o and zero data.
//   - the read port goes to dm reads by default; after STARVE_MAX consecutive
//     fetch losses the fetch port wins. One read grant per cycle, no bubbles.
//   - the RAM returns data one cycle after rd_en; a small owner register
//     routes that data to the right requester.
//
// Configuration macro:
//   IRAM_ARB_FWD_EN : when defined, a fetch read of the word being written
//                     in the same cycle returns the newly written bytes
//                     (per byte enable) merged with RAM data. When undefined,
//                     the RAM's read-during-write (old) data is returned.
//
// Ports:
//   clk_i, rst_n_i                 clock, async active-low reset
//   if_req_i/if_addr_i             fetch read request, byte address
//   if_gnt_o                       fetch accepted this cycle
//   if_rvalid_o/if_rdata_o         fetch response (one cycle after grant)
//   dm_req_i/dm_we_i/dm_addr_i     data-port request, write flag, byte address
//   dm_wdata_i/dm_be_i             write data and byte enables
//   dm_gnt_o                       data request accepted this cycle
//   dm_rvalid_o/dm_rdata_o         read data / write ack (one cycle after grant)
//   ram_wr_en_o/ram_wr_addr_o      RAM write port (word address)
//   ram_wr_data_o/ram_wr_byte_en_o RAM write data and byte enables
//   ram_rd_en_o/ram_rd_addr_o      RAM read port (word address)
//   ram_rd_data_i                  RAM q, valid one cycle after rd_en
// -----------------------------------------------------------------------------
module iram_arb
  import iram_arb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ADDR_W     = 13,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              if_req_i,
  input  logic [XLEN-1:0]   if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [XLEN-1:0]   if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [XLEN-1:0]   dm_addr_i,
  input  logic [XLEN-1:0]   dm_wdata_i,
  input  logic [3:0]        dm_be_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [XLEN-1:0]   dm_rdata_o,
  output logic              ram_wr_en_o,
  output logic              ram_rd_en_o,
  output logic [ADDR_W-1:0] ram_wr_addr_o,
  output logic [ADDR_W-1:0] ram_rd_addr_o,
  output logic [XLEN-1:0]   ram_wr_data_o,
  output logic [3:0]        ram_wr_byte_en_o,
  input  logic [XLEN-1:0]   ram_rd_data_i
);

  localparam int CNT_W  = $clog2(STARVE_MAX + 1);
  localparam int LANE_W = XLEN / 4;

  owner_e           r_state;
  logic [CNT_W-1:0] r_starve;
  logic             r_wr_ack;

  logic              w_dm_wr;
  logic              w_dm_rd;
  logic              w_if_rd;
  logic              w_starved;
  logic              w_if_gnt;
  logic              w_dm_rd_gnt;
  logic [ADDR_W-1:0] w_if_word;
  logic [ADDR_W-1:0] w_dm_word;
  logic [XLEN-1:0]   w_rd_data;

  // Word addresses: byte offset bits [1:0] and anything above the RAM are
  // dropped. The reduction keeps the dropped bits visibly consumed.
  assign w_if_word = if_addr_i[ADDR_W+1:2];
  assign w_dm_word = dm_addr_i[ADDR_W+1:2];

  logic w_unused;
  assign w_unused = ^{if_addr_i[XLEN-1:ADDR_W+2], if_addr_i[1:0],
                      dm_addr_i[XLEN-1:ADDR_W+2], dm_addr_i[1:0]};

  // Requests are masked while reset is held so no grant or RAM enable can
  // escape during reset.
  assign w_dm_wr = rst_n_i & dm_req_i &  dm_we_i;
  assign w_dm_rd = rst_n_i & dm_req_i & ~dm_we_i;
  assign w_if_rd = rst_n_i & if_req_i;

  // Read-port arbitration: dm reads win unless fetch has lost STARVE_MAX
  // cycles in a row. A dm write never competes for the read port.
  assign w_starved   = (r_starve == CNT_W'(STARVE_MAX));
  assign w_if_gnt    = w_if_rd & (~w_dm_rd | w_starved);
  assign w_dm_rd_gnt = w_dm_rd & ~w_if_gnt;

  assign if_gnt_o = w_if_gnt;
  assign dm_gnt_o = w_dm_wr | w_dm_rd_gnt;

  assign ram_wr_en_o      = w_dm_wr;
  assign ram_wr_addr_o    = w_dm_word;
  assign ram_wr_data_o    = dm_wdata_i;
  assign ram_wr_byte_en_o = dm_be_i;

  assign ram_rd_en_o   = w_if_gnt | w_dm_rd_gnt;
  assign ram_rd_addr_o = w_if_gnt ? w_if_word : w_dm_word;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= ST_IDLE;
      r_starve <= '0;
      r_wr_ack <= 1'b0;
    end else begin
      // Owner of the response arriving next cycle; no grant means no response.
      if (w_if_gnt)         r_state <= ST_IF_PEND;
      else if (w_dm_rd_gnt) r_state <= ST_DM_PEND;
      else                  r_state <= ST_IDLE;

      // Consecutive-loss counter, saturating at STARVE_MAX.
      if (w_if_rd && !w_if_gnt) begin
        if (!w_starved) r_starve <= r_starve + CNT_W'(1);
      end else begin
        r_starve <= '0;
      end

      r_wr_ack <= w_dm_wr;
    end
  end

`ifdef IRAM_ARB_FWD_EN
  // Bytes written in the same cycle a fetch read hits that word; merged over
  // the RAM's old data when the response comes back.
  logic [XLEN-1:0] r_fwd_data;
  logic [3:0]      r_fwd_mask;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_fwd_data <= '0;
      r_fwd_mask <= '0;
    end else begin
      r_fwd_data <= dm_wdata_i;
      // Only fetch can collide: a dm read and dm write never share a cycle.
      if (w_if_gnt && w_dm_wr && (w_if_word == w_dm_word)) r_fwd_mask <= dm_be_i;
      else                                                 r_fwd_mask <= '0;
    end
  end

  // NOTE: every bit is assigned before any conditional override, so this
  // block cannot infer a latch.
  always_comb begin
    w_rd_data = ram_rd_data_i;
    for (int i = 0; i < 4; i++) begin
      if (r_fwd_mask[i]) w_rd_data[i*LANE_W +: LANE_W] = r_fwd_data[i*LANE_W +: LANE_W];
    end
  end
`else
  assign w_rd_data = ram_rd_data_i;
`endif

  assign if_rvalid_o = (r_state == ST_IF_PEND);
  assign if_rdata_o  = (r_state == ST_IF_PEND) ? w_rd_data : '0;

  // A write ack and a dm read response can never be pending together.
  assign dm_rvalid_o = (r_state == ST_DM_PEND) | r_wr_ack;
  assign dm_rdata_o  = (r_state == ST_DM_PEND) ? w_rd_data : '0;

endmodule : iram_arb

// File: doc/iram_arb.md
IRAM_ARB -- requirements
Module: iram_arb

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/address width.
REQ-002 SHALL have parameter ADDR_W, default 13, meaning RAM word-address width (8K words = 32 KiB).
REQ-003 SHALL have parameter STARVE_MAX, default 4, meaning consecutive fetch losses before fetch wins.
REQ-004 SHALL have ports, one clock, reset asynchronous active-low:
  clk_i  in  1  clock
  rst_n_i  in  1  async active-low reset
  if_req_i  in  1  fetch read request
  if_addr_i  in  XLEN  fetch byte address
  if_gnt_o  out  1  fetch request accepted this cycle
  if_rvalid_o  out  1  fetch data valid
  if_rdata_o  out  XLEN  fetch data
  dm_req_i  in  1  data-port request
  dm_we_i  in  1  1 = write, 0 = read
  dm_addr_i  in  XLEN  data byte address
  dm_wdata_i  in  XLEN  write data
  dm_be_i  in  4  write byte enables
  dm_gnt_o  out  1  data request accepted this cycle
  dm_rvalid_o  out  1  data read valid / write ack
  dm_rdata_o  out  XLEN  data read data
  ram_wr_en_o, ram_rd_en_o  out  1  RAM port enables
  ram_wr_addr_o, ram_rd_addr_o  out  ADDR_W  RAM word addresses
  ram_wr_data_o  out  XLEN  RAM write data
  ram_wr_byte_en_o  out  4  RAM byte enables
  ram_rd_data_i  in  XLEN  RAM q, valid one cycle after rd_en

Function
REQ-005 SHALL drive RAM word address = byte address bits [ADDR_W+1:2]; bits [1:0] ignored.
REQ-006 SHALL grant a dm write (dm_req_i & dm_we_i) unconditionally in the same cycle, driving the write port combinationally.
REQ-007 SHALL assert dm_rvalid_o one cycle after a granted write, with dm_rdata_o = 0.
REQ-008 SHALL arbitrate the single read port between fetch and dm reads; winner gets gnt and ram_rd_en_o in the same cycle.
REQ-009 SHALL give dm reads priority unless starve counter == STARVE_MAX, then fetch wins.
REQ-010 SHALL increment starve counter on each cycle fetch requests and loses; clear it when fetch is granted or not requesting; saturate at STARVE_MAX.
REQ-011 SHALL track the read owner with a state register: IDLE, IF_PEND, DM_PEND; a grant sets IF_PEND/DM_PEND for the next cycle, else IDLE.
REQ-012 SHALL in IF_PEND assert if_rvalid_o with if_rdata_o = ram_rd_data_i; in DM_PEND likewise for dm; otherwise rdata outputs = 0.
REQ-013 SHALL sustain one read grant per cycle (back-to-back, no bubbles).
REQ-014 SHALL allow a dm write and a fetch read in the same cycle; a dm read and dm write cannot coexist (single dm request).
REQ-015 SHALL drop gnt when the corresponding req is low; requesters hold req/addr until gnt.

Reset
REQ-016 SHALL on rst_n_i low: state IDLE, starve counter 0, all gnt/rvalid/enable outputs 0, rdata 0.
REQ-017 SHALL discard any pending read response when reset asserts mid-operation; no rvalid after release until a new grant.

Configuration
REQ-018 SHALL, with IRAM_ARB_FWD_EN defined, forward same-cycle writes: if a read is granted to the word being written that cycle, returned data uses written bytes where dm_be_i set, RAM data elsewhere (one extra XLEN data + 4-bit mask register).
REQ-019 SHALL, without IRAM_ARB_FWD_EN, return RAM read-during-write (old) data, no forwarding logic.

Structure
REQ-020 SHALL place owner-state enum (IDLE/IF_PEND/DM_PEND) and STARVE_MAX default in shared package iram_arb_pkg.
REQ-021 SHALL contain no sub-module; RAM instance stays outside, connected by the ram_* ports.

Verification
REQ-022 Fetch only, if_addr 0x100 -> if_gnt same cycle, ram_rd_addr 0x40, if_rvalid next cycle with RAM word.
REQ-023 Both read every cycle -> dm granted 4 cycles, fetch 5th, pattern repeats; no cycle without a grant.
REQ-024 dm write 0xDEADBEEF be 0xF to 0x200 plus fetch 0x200 same cycle -> FWD_EN: if_rdata 0xDEADBEEF; else old word.
REQ-025 dm write be 0x3 data 0x1234_5678 to addr 0x8 -> ram_wr_byte_en 0x3, ram_wr_addr 0x2, dm_rvalid next cycle.
REQ-026 Reset asserted in IF_PEND -> if_rvalid 0 during and after reset until next grant.
REQ-027 Alternating dm read/write with continuous fetch -> every dm write granted immediately, fetch granted on write cycles.
